// File: rtl/mux_arb_pkg.sv
// Shared widths and output-stage state encoding for the 2:1 byte arbiter.
package mux_arb_pkg;

   localparam int DATA_W = 8;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

endpackage

// File: rtl/mux_arb_ctrl_if.sv
// Byte channels around the arbiter: two producers, one consumer, plus grant status.
interface mux_arb_ctrl_if;
   import mux_arb_pkg::*;

   logic [DATA_W-1:0] in0_data;
   logic              in0_valid;
   logic              in0_ready;
   logic [DATA_W-1:0] in1_data;
   logic              in1_valid;
   logic              in1_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              sel;
   logic              owner;

   modport master (
      output in0_data, in0_valid, in1_data, in1_valid, out_ready,
      input  in0_ready, in1_ready, out_data, out_valid, sel, owner
   );

   modport slave (
      input  in0_data, in0_valid, in1_data, in1_valid, out_ready,
      output in0_ready, in1_ready, out_data, out_valid, sel, owner
   );

endinterface

// File: rtl/mux_2to1.sv
// Plain 2:1 data mux; select=0 passes a, select=1 passes b.
module mux_2to1 #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             select,
   output logic [WIDTH-1:0] y
);

   assign y = select ? b : a;

endmodule

// File: rtl/mux_arb_ctrl.sv
// Round-robin arbiter with bounded bursts feeding a single-entry output register.
//   state     | meaning
//   OUT_EMPTY | output register holds no untaken byte
//   OUT_FULL  | out_data valid, waiting for the consumer
module mux_arb_ctrl
   import mux_arb_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   mux_arb_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

   out_state_t        state;
   logic [DATA_W-1:0] out_data;
   logic              owner;
   logic [CNT_W-1:0]  burst_cnt;

   logic              accept;
   logic              grant;
   logic              xfer;
   logic [DATA_W-1:0] mux_y;

   assign accept = (state == OUT_EMPTY) || bus.out_ready;

   // The burst limit only bites under contention; a lone requester always wins.
   always_comb begin
      grant = owner;
      unique case ({bus.in1_valid, bus.in0_valid})
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = (burst_cnt < MAX_CNT) ? owner : !owner;
         default: grant = owner;
      endcase
   end

   assign xfer = accept && (grant ? bus.in1_valid : bus.in0_valid);

   mux_2to1 #(
      .WIDTH (DATA_W)
   ) u_mux (
      .a      (bus.in0_data),
      .b      (bus.in1_data),
      .select (grant),
      .y      (mux_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= OUT_EMPTY;
         out_data  <= '0;
         owner     <= 1'b0;
         burst_cnt <= '0;
      end else begin
         unique case (state)
            OUT_EMPTY: if (xfer) state <= OUT_FULL;
            OUT_FULL:  if (bus.out_ready && !xfer) state <= OUT_EMPTY;
            default:   state <= OUT_EMPTY;
         endcase
         if (xfer) begin
            out_data <= mux_y;
            if (grant == owner) begin
               if (burst_cnt != MAX_CNT) burst_cnt <= burst_cnt + 1'b1;
            end else begin
               owner     <= grant;
               burst_cnt <= CNT_W'(1);
            end
         end
      end
   end

   assign bus.sel       = grant;
   assign bus.in0_ready = accept && !grant;
   assign bus.in1_ready = accept && grant;
   assign bus.out_data  = out_data;
   assign bus.out_valid = (state == OUT_FULL);
   assign bus.owner     = owner;

endmodule

// File: tb/tb_mux_arb_ctrl.sv
// Bench for mux_arb_ctrl: per-cycle vector table plus scoreboarded multi-cycle sequences.
module tb_mux_arb_ctrl;

   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mux_arb_ctrl_if bus_a ();
   mux_arb_ctrl_if bus_b ();

   mux_arb_ctrl #(.MAX_BURST(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   mux_arb_ctrl #(.MAX_BURST(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   logic       v0, v1, o_ready, dsel;
   logic [7:0] d0, d1;
   int         rem0, rem1;

   assign bus_a.in0_data  = d0;
   assign bus_a.in0_valid = v0;
   assign bus_a.in1_data  = d1;
   assign bus_a.in1_valid = v1;
   assign bus_a.out_ready = o_ready;
   assign bus_b.in0_data  = d0;
   assign bus_b.in0_valid = v0;
   assign bus_b.in1_data  = d1;
   assign bus_b.in1_valid = v1;
   assign bus_b.out_ready = o_ready;

   logic       r0_m, r1_m, sel_m, ov_m, own_m;
   logic [7:0] od_m;
   assign r0_m  = dsel ? bus_b.in0_ready : bus_a.in0_ready;
   assign r1_m  = dsel ? bus_b.in1_ready : bus_a.in1_ready;
   assign sel_m = dsel ? bus_b.sel       : bus_a.sel;
   assign ov_m  = dsel ? bus_b.out_valid : bus_a.out_valid;
   assign own_m = dsel ? bus_b.owner     : bus_a.owner;
   assign od_m  = dsel ? bus_b.out_data  : bus_a.out_data;

   int n_pass, n_total;
   logic [7:0] exp_q[$];
   logic x0, x1;

   task automatic chk1(string name, logic act, logic exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", name, act, exp);
   endtask

   task automatic chk8(string name, logic [7:0] act, logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic chk_int(string name, int act, int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Mid-cycle observation: scoreboard any output take, remember input transfers.
   task automatic sample();
      logic [7:0] e;
      @(negedge clk);
      x0 = v0 && r0_m;
      x1 = v1 && r1_m;
      if (ov_m && o_ready) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL spurious_out: got %h expected no output", od_m);
         end else begin
            e = exp_q.pop_front();
            chk8("out_order", od_m, e);
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      if (x0) begin rem0--; d0 = d0 + 8'd1; v0 = (rem0 > 0); end
      if (x1) begin rem1--; d1 = d1 + 8'd1; v1 = (rem1 > 0); end
   endtask

   task automatic drain(string name, int bound);
      for (int c = 0; c < bound && exp_q.size() > 0; c++) begin
         sample();
         advance();
      end
      chk_int(name, exp_q.size(), 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      v0 = 1'b0; v1 = 1'b0; rem0 = 0; rem1 = 0;
      d0 = 8'h00; d1 = 8'h00; o_ready = 1'b1;
      x0 = 1'b0; x1 = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   typedef struct {
      logic       v0;
      logic [7:0] d0;
      logic       v1;
      logic [7:0] d1;
      logic       ordy;
      logic       e_r0;
      logic       e_r1;
      logic       e_sel;
      logic       e_ov;
      logic [7:0] e_od;
      logic       e_own;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int n;
      n_pass = 0; n_total = 0; dsel = 1'b0;

      //            v0  d0     v1  d1     ordy  r0  r1  sel ov  od     own
      tbl[0] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
      tbl[1] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
      tbl[2] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
      tbl[3] = '{1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1};
      tbl[5] = '{1'b1, 8'hC3, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1};
      tbl[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1};
      tbl[7] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1};
      tbl[8] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1};

      do_reset();
      for (int i = 0; i < 9; i++) begin
         v0 = tbl[i].v0; d0 = tbl[i].d0;
         v1 = tbl[i].v1; d1 = tbl[i].d1;
         o_ready = tbl[i].ordy;
         @(negedge clk);
         chk1($sformatf("vec%0d_in0_ready", i), r0_m, tbl[i].e_r0);
         chk1($sformatf("vec%0d_in1_ready", i), r1_m, tbl[i].e_r1);
         chk1($sformatf("vec%0d_sel", i), sel_m, tbl[i].e_sel);
         chk1($sformatf("vec%0d_out_valid", i), ov_m, tbl[i].e_ov);
         chk8($sformatf("vec%0d_out_data", i), od_m, tbl[i].e_od);
         chk1($sformatf("vec%0d_owner", i), own_m, tbl[i].e_own);
         @(posedge clk);
         #1;
      end

      // Contention with MAX_BURST=4: groups of four from each side.
      do_reset();
      rem0 = 16; rem1 = 16; d0 = 8'h10; d1 = 8'h90; v0 = 1'b1; v1 = 1'b1;
      begin
         int n0, n1;
         n0 = 0; n1 = 0;
         for (int i = 0; i < 32; i++) begin
            if (((i / 4) % 2) == 0) begin exp_q.push_back(8'h10 + 8'(n0)); n0++; end
            else begin exp_q.push_back(8'h90 + 8'(n1)); n1++; end
         end
      end
      drain("burst4_drain", 100);

      // Lone in1 requester: never throttled, counter saturates.
      do_reset();
      rem1 = 10; d1 = 8'h40; v1 = 1'b1;
      for (int i = 0; i < 10; i++) exp_q.push_back(8'h40 + 8'(i));
      drain("lone_in1_drain", 40);
      chk8("lone_burst_cnt", 8'(u_a.burst_cnt), 8'd4);
      chk1("lone_owner", own_m, 1'b1);

      // Backpressure on a held 3C.
      do_reset();
      o_ready = 1'b0; rem0 = 1; d0 = 8'h3C; v0 = 1'b1;
      exp_q.push_back(8'h3C);
      sample();
      advance();
      rem0 = 1; d0 = 8'h11; v0 = 1'b1;
      rem1 = 1; d1 = 8'h22; v1 = 1'b1;
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      for (int i = 0; i < 5; i++) begin
         sample();
         chk8("bp_out_data", od_m, 8'h3C);
         chk1("bp_out_valid", ov_m, 1'b1);
         chk1("bp_in0_ready", r0_m, 1'b0);
         chk1("bp_in1_ready", r1_m, 1'b0);
         advance();
      end
      chk_int("bp_rem0", rem0, 1);
      chk_int("bp_rem1", rem1, 1);
      o_ready = 1'b1;
      drain("bp_drain", 20);
      sample();
      chk1("bp_empty_after", ov_m, 1'b0);
      advance();

      // Async reset while FULL with 77.
      do_reset();
      o_ready = 1'b0; rem0 = 1; d0 = 8'h77; v0 = 1'b1;
      sample();
      advance();
      sample();
      chk1("rst_full_valid", ov_m, 1'b1);
      chk8("rst_full_data", od_m, 8'h77);
      #2 rst_n = 1'b0;
      #1 chk1("rst_async_drop", ov_m, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1; o_ready = 1'b1; v0 = 1'b0; rem0 = 0;
      for (int i = 0; i < 5; i++) begin
         sample();
         chk1("rst_no_replay", ov_m, 1'b0);
         advance();
      end
      chk1("rst_owner", own_m, 1'b0);

      // MAX_BURST=1: strict alternation.
      dsel = 1'b1;
      do_reset();
      rem0 = 6; rem1 = 6; d0 = 8'h20; d1 = 8'hA0; v0 = 1'b1; v1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(8'h20 + 8'(i));
         exp_q.push_back(8'hA0 + 8'(i));
      end
      n = 0;
      for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
         sample();
         if (x0 || x1) begin
            chk1("alt_sel", sel_m, n[0]);
            n++;
         end
         advance();
      end
      chk_int("alt_drain", exp_q.size(), 0);
      chk_int("alt_xfers", n, 12);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
